// File: rtl/counter_display_driver_pkg.sv
// Shared constants for the two-digit counter display: active-high segment codes,
// digit-enable patterns, scan-state encoding and polarity helpers.
package counter_display_driver_pkg;

    localparam logic [6:0] SEG_CODE_0 = 7'h3F;
    localparam logic [6:0] SEG_CODE_1 = 7'h06;
    localparam logic [6:0] SEG_CODE_2 = 7'h5B;
    localparam logic [6:0] SEG_CODE_3 = 7'h4F;
    localparam logic [6:0] SEG_CODE_4 = 7'h66;
    localparam logic [6:0] SEG_CODE_5 = 7'h6D;
    localparam logic [6:0] SEG_CODE_6 = 7'h7D;
    localparam logic [6:0] SEG_CODE_7 = 7'h07;
    localparam logic [6:0] SEG_CODE_8 = 7'h7F;
    localparam logic [6:0] SEG_CODE_9 = 7'h6F;

    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [1:0] DIG_OFF  = 2'b00;
    localparam logic [1:0] DIG_ONES = 2'b01;
    localparam logic [1:0] DIG_TENS = 2'b10;

    localparam logic [0:0] STATE_ONES = 1'b0;
    localparam logic [0:0] STATE_TENS = 1'b1;

    function automatic logic [6:0] seg_drive(input logic [6:0] pattern, input bit active_low);
        return active_low ? ~pattern : pattern;
    endfunction

    function automatic logic [1:0] dig_drive(input logic [1:0] sel, input bit active_low);
        return active_low ? ~sel : sel;
    endfunction

endpackage

// File: rtl/seven_segment_encoder.sv
// Decimal digit to active-high g..a segment pattern; non-decimal inputs blank.
module seven_segment_encoder
    import counter_display_driver_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_pattern
);

    always_comb begin
        o_pattern = SEG_OFF;
        case (i_digit)
            4'd0:    o_pattern = SEG_CODE_0;
            4'd1:    o_pattern = SEG_CODE_1;
            4'd2:    o_pattern = SEG_CODE_2;
            4'd3:    o_pattern = SEG_CODE_3;
            4'd4:    o_pattern = SEG_CODE_4;
            4'd5:    o_pattern = SEG_CODE_5;
            4'd6:    o_pattern = SEG_CODE_6;
            4'd7:    o_pattern = SEG_CODE_7;
            4'd8:    o_pattern = SEG_CODE_8;
            4'd9:    o_pattern = SEG_CODE_9;
            default: o_pattern = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/counter_display_driver.sv
// Two-digit multiplexed seven-segment driver for a 0-15 counter value, with
// tens-digit blanking and a value captured once per scan frame.
module counter_display_driver
    import counter_display_driver_pkg::*;
#(
    parameter int unsigned REFRESH_BITS       = 16,
    parameter bit          SEGMENT_ACTIVE_LOW = 1'b1,
    parameter bit          DIGIT_ACTIVE_LOW   = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] counter,
    input  logic       enable,
    output logic [6:0] segments,
    output logic [1:0] digitSelect,
    output logic       frameStrobe
);

    logic [REFRESH_BITS-1:0] r_prescaler;
    logic [0:0]              r_state;
    logic [3:0]              r_latched;
    logic                    r_frame_start;
    logic                    r_strobe;
    logic [6:0]              r_segments;
    logic [1:0]              r_digits;

    logic       w_tick;
    logic       w_is_tens;
    logic [3:0] w_ones;
    logic [3:0] w_enc_digit;
    logic [6:0] w_pattern;
    logic [6:0] w_seg_next;
    logic [1:0] w_dig_next;

    assign w_tick      = &r_prescaler;
    assign w_is_tens   = (r_latched >= 4'd10);
    assign w_ones      = w_is_tens ? (r_latched - 4'd10) : r_latched;
    assign w_enc_digit = (r_state == STATE_ONES) ? w_ones : 4'd1;

    seven_segment_encoder u_encoder (
        .i_digit   (w_enc_digit),
        .o_pattern (w_pattern)
    );

    // TENS phase with a value below ten stays dark (leading-zero blank).
    always_comb begin
        w_seg_next = SEG_OFF;
        w_dig_next = DIG_OFF;
        if (enable) begin
            if (r_state == STATE_ONES) begin
                w_seg_next = w_pattern;
                w_dig_next = DIG_ONES;
            end else if (w_is_tens) begin
                w_seg_next = w_pattern;
                w_dig_next = DIG_TENS;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prescaler   <= '0;
            r_state       <= STATE_ONES;
            r_latched     <= 4'd0;
            r_frame_start <= 1'b0;
            r_strobe      <= 1'b0;
            r_segments    <= seg_drive(SEG_OFF, SEGMENT_ACTIVE_LOW);
            r_digits      <= dig_drive(DIG_OFF, DIGIT_ACTIVE_LOW);
        end else begin
            r_prescaler   <= r_prescaler + REFRESH_BITS'(1);
            r_frame_start <= w_tick && (r_state == STATE_TENS);
            // Strobe lines up with the first output cycle showing the new capture.
            r_strobe      <= r_frame_start;
            r_segments    <= seg_drive(w_seg_next, SEGMENT_ACTIVE_LOW);
            r_digits      <= dig_drive(w_dig_next, DIGIT_ACTIVE_LOW);
            if (w_tick) begin
                r_state <= (r_state == STATE_ONES) ? STATE_TENS : STATE_ONES;
                if (r_state == STATE_TENS) begin
                    r_latched <= counter;
                end
            end
        end
    end

    assign segments    = r_segments;
    assign digitSelect = r_digits;
    assign frameStrobe = r_strobe;

endmodule

// File: doc/counter_display_driver.md
Name: counter_display_driver

Overview:
Downstream consumer of the 4-bit up/down counter with load. Shows the counter value (0-15) in decimal on a two-digit multiplexed seven-segment display, with tens-digit leading-zero blanking. The displayed value is captured once per scan frame, so a digit never tears mid-frame. Runs on the fast system clock, not the debouncing clock; the counter value enters from the slower domain as a quasi-static bus.

Parameters:
REFRESH_BITS, 16, width of the scan prescaler; each digit is held for 2^REFRESH_BITS clocks.
SEGMENT_ACTIVE_LOW, 1, 1 = segment lines drive 0 to light.
DIGIT_ACTIVE_LOW, 1, 1 = digit enables drive 0 to select.

Ports:
clock  input  1  system clock; all state on its rising edge.
reset  input  1  asynchronous, active-low (0 = in reset); clears all state immediately.
counter  input  4  unsigned value to display (0-15).
enable  input  1  1 = display on; 0 = all segments and digits off.
segments  output  7  segments[0]=a ... segments[6]=g, polarity per SEGMENT_ACTIVE_LOW.
digitSelect  output  2  [0]=ones digit, [1]=tens digit, polarity per DIGIT_ACTIVE_LOW.
frameStrobe  output  1  one-clock pulse when a newly captured value starts displaying.

Behaviour:
- Reset (reset=0, asynchronous): prescaler=0, scan state=ONES, latched value=0, segments=all off, digitSelect=all off, frameStrobe=0. Active-low defaults give segments=7'h7F and digitSelect=2'b11.
- Prescaler: free-running REFRESH_BITS-bit up-counter that wraps. tick=1 when prescaler is all ones.
- Scan FSM: two states, ONES and TENS. On a tick edge, ONES->TENS or TENS->ONES; otherwise the state holds.
- Capture: on the tick edge that moves TENS->ONES, latched<=counter. A counter change at any other time is ignored until the next frame start.
- BCD: tens=(latched>=10); ones=latched-10 if latched>=10, else latched. This is 4-bit arithmetic with no divider.
- Encoding, active-high, g..a: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Each code is inverted when SEGMENT_ACTIVE_LOW=1.
- Outputs are registered from the current scan state and latched value, so they lag the scan state by 1 clock. Each phase is visible for exactly 2^REFRESH_BITS clocks.
  - ONES phase: digitSelect selects only digit 0; segments show ones.
  - TENS phase with tens=1: selects only digit 1; segments show "1".
  - TENS phase with tens=0: leading-zero blank; digitSelect all off and segments all off.
- enable=0: the next registered outputs are all off. The prescaler, FSM, capture and frameStrobe keep running, so re-enabling resumes mid-frame with no restart.
- frameStrobe: registered, high for exactly the 1 clock in which the outputs first show the newly captured ONES digit. There is no strobe for the first frame after reset; that frame shows latched=0, i.e. "0".
- Reset asserted mid-frame: outputs go off without waiting for a clock edge. After release, scanning restarts at ONES with prescaler=0.
- Digit select and segments change on the same edge, so no mixed-digit cycle occurs.

Decomposition:
- Shared package/header holds:
  - the ten segment code constants and the SEG_OFF/SEG_ON-style polarity constants;
  - the ONES/TENS state encoding.
- One sub-module, seven_segment_encoder: combinational 4-bit digit to 7-bit active-high pattern, with polarity applied in counter_display_driver.
- Prescaler, FSM, capture and output registers stay in counter_display_driver.

Test Plan:
- Run all directed tests with REFRESH_BITS=2 and both ACTIVE_LOW parameters at 1, so each phase lasts 4 clocks.
1. Reset: hold reset=0 with clock running -> segments=7'h7F, digitSelect=2'b11, frameStrobe=0 throughout.
2. counter=7, enable=1 -> ONES phase: digitSelect=2'b10, segments=7'h78 for 4 clocks. TENS phase: digitSelect=2'b11, segments=7'h7F (blanked). Pattern repeats every 8 clocks, with frameStrobe pulsing once per 8.
3. counter=13 -> ONES: digitSelect=2'b10, segments=7'h30 ("3"). TENS: digitSelect=2'b01, segments=7'h79 ("1").
4. counter changes 7->12 during a ONES phase -> remaining ONES and TENS still show 7/blank. The next ONES shows 7'h24 ("2") and TENS shows 7'h79, with frameStrobe=1 on the first "2" clock.
5. enable=0 for 12 clocks with counter=9 -> segments=7'h7F and digitSelect=2'b11 one clock after enable falls. frameStrobe still pulses every 8 clocks. On re-enable, the display resumes in the correct phase.
6. Assert reset=0 asynchronously mid-TENS with counter=15 -> outputs go to off before the next clock edge. After release, the first frame shows "0", with no frameStrobe until the second frame, which shows 15.
